// File: rtl/reduce_gate_seq_pkg.sv
// Shared definitions for the reduce_gate_seq block.
//
// Holds the mode-select encodings for the reduction gate and the FSM state
// constants used by the self-sweep controller. The states are plain localparam
// constants rather than an enum so legacy tools can consume the same package.
package reduce_gate_seq_pkg;

  // Mode-select encodings. Codes 6 and 7 are reserved and produce a 0 result.
  localparam int unsigned MODE_AND  = 0;
  localparam int unsigned MODE_OR   = 1;
  localparam int unsigned MODE_XOR  = 2;
  localparam int unsigned MODE_XNOR = 3;
  localparam int unsigned MODE_NAND = 4;
  localparam int unsigned MODE_NOR  = 5;

  // Sweep controller states.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

endpackage

// File: rtl/reduce_gate_core.sv
// Combinational mode-selected reduction over a WIDTH-bit operand.
//
// Ports:
//   data_i  operand bits, bit 0 is the first gate input
//   mode_i  function select (AND, OR, XOR, XNOR, NAND, NOR; others reserved)
//   y_o     reduction result, 0 for reserved modes
module reduce_gate_core
  import reduce_gate_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MODE_W = 3
) (
  input  logic [WIDTH-1:0]  data_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic              y_o
);

  logic all_ones;
  logic any_one;
  logic parity;

  // The six functions are all derived from these three primitive reductions.
  assign all_ones = &data_i;
  assign any_one  = |data_i;
  assign parity   = ^data_i;

  always_comb begin
    y_o = 1'b0;
    case (mode_i)
      MODE_W'(MODE_AND):  y_o = all_ones;
      MODE_W'(MODE_OR):   y_o = any_one;
      MODE_W'(MODE_XOR):  y_o = parity;
      MODE_W'(MODE_XNOR): y_o = ~parity;
      MODE_W'(MODE_NAND): y_o = ~all_ones;
      MODE_W'(MODE_NOR):  y_o = ~any_one;
      default:            y_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/reduce_gate_seq.sv
// Registered reduction gate with valid/ready handshakes and an exhaustive
// self-sweep that counts how many of the 2^WIDTH input patterns give y=1.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   mode         function select, sampled with in_data on acceptance
//   in_valid     in_data/mode are valid
//   in_data      operand bits
//   in_ready     operand accepted this cycle when in_valid is also high
//   out_valid    out_y holds a result
//   out_y        registered reduction result
//   out_ready    consumer takes the result
//   sweep_start  request an exhaustive self-sweep (honoured only in idle)
//   sweep_busy   high while the sweep walks the patterns
//   sweep_done   one-cycle pulse after the last pattern
//   sweep_ones   number of patterns with y=1 in the most recent sweep
module reduce_gate_seq
  import reduce_gate_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] mode,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_y,
  input  logic              out_ready,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [WIDTH:0]    sweep_ones
);

  localparam int unsigned PatW = WIDTH + 1;
  // Final pattern compared explicitly so the sweep never depends on wrap.
  localparam logic [PatW-1:0] LastPat = PatW'((64'd1 << WIDTH) - 64'd1);

  logic [1:0]        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              out_y_q, out_y_d;
  logic [MODE_W-1:0] sweep_mode_q, sweep_mode_d;
  logic [PatW-1:0]   pat_q, pat_d;
  logic [PatW-1:0]   ones_q, ones_d;

  logic              in_sweep;
  logic              accept;
  logic [WIDTH-1:0]  core_data;
  logic [MODE_W-1:0] core_mode;
  logic              core_y;

  assign in_sweep = (state_q == StSweep);

  // A pending sweep request blocks the operand so the sweep wins a tie.
  assign in_ready = (state_q == StIdle) && !sweep_start && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // One shared gate: the sweep borrows it, normal traffic uses it otherwise.
  assign core_data = in_sweep ? pat_q[WIDTH-1:0] : in_data;
  assign core_mode = in_sweep ? sweep_mode_q : mode;

  reduce_gate_core #(
    .WIDTH  (WIDTH),
    .MODE_W (MODE_W)
  ) u_core (
    .data_i (core_data),
    .mode_i (core_mode),
    .y_o    (core_y)
  );

  // Sweep controller.
  always_comb begin
    state_d      = state_q;
    sweep_mode_d = sweep_mode_q;
    pat_d        = pat_q;
    ones_d       = ones_q;
    case (state_q)
      StIdle: begin
        if (sweep_start) begin
          state_d      = StSweep;
          sweep_mode_d = mode;
          pat_d        = '0;
          ones_d       = '0;
        end
      end
      StSweep: begin
        if (core_y) begin
          ones_d = ones_q + PatW'(1);
        end
        if (pat_q == LastPat) begin
          state_d = StDone;
        end else begin
          pat_d = pat_q + PatW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Result register. Sweep evaluations never reach it because accept is
  // impossible outside idle, so a held result survives a sweep untouched.
  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_y_d     = core_y;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      out_valid_q  <= 1'b0;
      out_y_q      <= 1'b0;
      sweep_mode_q <= '0;
      pat_q        <= '0;
      ones_q       <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_y_q      <= out_y_d;
      sweep_mode_q <= sweep_mode_d;
      pat_q        <= pat_d;
      ones_q       <= ones_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign sweep_busy = in_sweep;
  assign sweep_done = (state_q == StDone);
  assign sweep_ones = ones_q;

endmodule
